led_blink_decoder: RTL and testbench

LED_BLINK_DECODER -- requirements
Module: led_blink_decoder

---
 rtl/led_blink_decoder_pkg.sv | 59 +++++
 rtl/led_blink_decoder_period_meter.sv | 130 +++++++++++++
 rtl/led_blink_decoder.sv | 164 ++++++++++++++++
 tb/tb_led_blink_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_decoder_pkg.sv
// ============================================================================
// Module      : led_blink_decoder_pkg
// Description : Shared status-code constants, channel-class enum, FSM state
//               encodings and classification helpers for the LED blink
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_blink_decoder_pkg;

  // Status codes; truncated to the output width at the point of use, so
  // the all-ones UNKNOWN code stays all-ones for any width.
  localparam logic [31:0] CODE_NORMAL  = 32'd0;
  localparam logic [31:0] CODE_WARN    = 32'd1;
  localparam logic [31:0] CODE_ERROR   = 32'd2;
  localparam logic [31:0] CODE_UNKNOWN = 32'hFFFF_FFFF;

  // Per-channel blink class
  typedef enum logic [2:0] {
    CLS_INVALID    = 3'd0,
    CLS_FAST       = 3'd1,
    CLS_SLOW       = 3'd2,
    CLS_STEADY_ON  = 3'd3,
    CLS_STEADY_OFF = 3'd4
  } led_class_e;

  // Decoder FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // Map a measured half-period onto a blink class using half-open windows
  function automatic led_class_e classify_half_period(
    input logic [31:0] h,
    input logic [31:0] fast_lo,
    input logic [31:0] fast_hi,
    input logic [31:0] slow_lo,
    input logic [31:0] slow_hi
  );
    led_class_e c;
    c = CLS_INVALID;
    if ((h >= fast_lo) && (h < fast_hi)) begin
      c = CLS_FAST;
    end else if ((h >= slow_lo) && (h < slow_hi)) begin
      c = CLS_SLOW;
    end
    return c;
  endfunction

  // True for the two classes that carry status information
  function automatic logic is_blink_class(input led_class_e c);
    return (c == CLS_FAST) || (c == CLS_SLOW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_blink_decoder_period_meter.sv
// ============================================================================
// Module      : led_period_meter
// Description : One LED channel: 2-flop synchronizer, optional 3-sample
//               majority glitch filter, half-period counter and blink
//               classifier with two-edge stability qualification.
//               Optional feature macro: LED_DEC_GLITCH_FILTER_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_period_meter
  import led_blink_decoder_pkg::*;
#(
  parameter int   NB_FAST  = 24,
  parameter int   NB_SLOW  = 26,
  parameter logic MD_LIGHT = 1'b0
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_led,
  input  logic       i_clear,
  output logic       o_level,
  output led_class_e o_class,
  output logic       o_stable,
  output logic       o_update
);

  localparam logic [31:0] C_SAT     = 32'd1 << (NB_SLOW + 2);
  localparam logic [31:0] C_FAST_LO = 32'd1 << (NB_FAST - 1);
  localparam logic [31:0] C_FAST_HI = 32'd1 << (NB_FAST + 1);
  localparam logic [31:0] C_SLOW_LO = 32'd1 << (NB_SLOW - 1);
  localparam logic [31:0] C_SLOW_HI = 32'd1 << (NB_SLOW + 1);

  logic        r_meta;
  logic        r_sync;
  logic        w_level;
  logic        r_prev;
  logic        w_edge;
  logic        w_saturated;
  logic [31:0] r_count;
  led_class_e  r_class;
  led_class_e  w_new_class;
  logic        r_stable;
  logic        r_update;

  // Two-flop synchronizer; resets to the unlit level so reset release does
  // not look like the LED turning on
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_meta <= ~MD_LIGHT;
      r_sync <= ~MD_LIGHT;
    end else begin
      r_meta <= i_led;
      r_sync <= r_meta;
    end
  end

`ifdef LED_DEC_GLITCH_FILTER_EN
  logic [2:0] r_hist;

  // Three-sample history; a 1-cycle pulse never occupies two slots
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_hist <= {3{~MD_LIGHT}};
    end else begin
      r_hist <= {r_hist[1:0], r_sync};
    end
  end

  assign w_level = (r_hist[0] & r_hist[1]) | (r_hist[1] & r_hist[2]) |
                   (r_hist[0] & r_hist[2]);
`else
  assign w_level = r_sync;
`endif

  assign w_edge      = w_level ^ r_prev;
  assign w_saturated = (r_count == C_SAT);
  assign w_new_class = classify_half_period(r_count, C_FAST_LO, C_FAST_HI,
                                            C_SLOW_LO, C_SLOW_HI);

  // Previous level for edge detection
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_prev <= ~MD_LIGHT;
    end else begin
      r_prev <= w_level;
    end
  end

  // Cycles since last edge: restarts at 1 on an edge, saturates at C_SAT
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_count <= 32'd0;
    end else if (w_edge) begin
      r_count <= 32'd1;
    end else if (!w_saturated) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Classify on each edge; stable only when two consecutive edges agree
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_class  <= CLS_INVALID;
      r_stable <= 1'b0;
      r_update <= 1'b0;
    end else if (i_clear) begin
      r_class  <= CLS_INVALID;
      r_stable <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_edge;
      if (w_edge) begin
        r_class  <= w_new_class;
        r_stable <= (w_new_class == r_class);
      end else if (w_saturated) begin
        r_stable <= 1'b0;
      end
    end
  end

  assign o_level  = w_level;
  assign o_class  = w_saturated ? ((w_level == MD_LIGHT) ? CLS_STEADY_ON : CLS_STEADY_OFF)
                                : r_class;
  assign o_stable = r_stable;
  assign o_update = r_update;

endmodule

`default_nettype wire

// File: rtl/led_blink_decoder.sv
// ============================================================================
// Module      : led_blink_decoder
// Description : Recovers a status code from the blink rates of an LED row.
//               led[1] arms the decoder, led[2]/led[3] blink rates select the
//               code, results are offered on a valid/ready interface.
//               Optional feature macro: LED_DEC_GLITCH_FILTER_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_decoder
  import led_blink_decoder_pkg::*;
#(
  parameter int   WD_LED   = 4,
  parameter int   WD_INFO  = 4,
  parameter logic MD_LIGHT = 1'b0,
  parameter int   NB_FAST  = 24,
  parameter int   NB_SLOW  = 26
) (
  input  logic               i_sys_clk,
  input  logic               i_rst_n,
  input  logic [WD_LED-1:0]  i_led_row,
  output logic [WD_INFO-1:0] o_info_data,
  output logic               o_info_valid,
  input  logic               i_info_ready,
  output logic               o_overrun,
  output logic               o_busy
);

  localparam logic [NB_FAST:0] C_HOLD_LAST = (NB_FAST + 1)'((1 << NB_FAST) - 1);

  logic               r_led0_meta;
  logic               r_led0_sync;
  logic               w_level  [1:3];
  led_class_e         w_class  [1:3];
  logic               w_stable [1:3];
  logic               w_update [1:3];
  logic               w_unused_hi;
  logic               w_unused;

  logic [1:0]         r_state;
  logic [WD_INFO-1:0] r_data;
  logic               r_overrun;
  logic [NB_FAST:0]   r_hold_cnt;

  logic               w_lit1;
  logic               w_clear;
  logic               w_qualify;
  logic [WD_INFO-1:0] w_code;

  // led[0] is brought into the clock domain but carries no decoded meaning
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_led0_meta <= ~MD_LIGHT;
      r_led0_sync <= ~MD_LIGHT;
    end else begin
      r_led0_meta <= i_led_row[0];
      r_led0_sync <= r_led0_meta;
    end
  end

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_meter
      led_period_meter #(
        .NB_FAST  (NB_FAST),
        .NB_SLOW  (NB_SLOW),
        .MD_LIGHT (MD_LIGHT)
      ) u_meter (
        .i_sys_clk (i_sys_clk),
        .i_rst_n   (i_rst_n),
        .i_led     (i_led_row[gi]),
        .i_clear   (w_clear),
        .o_level   (w_level[gi]),
        .o_class   (w_class[gi]),
        .o_stable  (w_stable[gi]),
        .o_update  (w_update[gi])
      );
    end

    if (WD_LED > 4) begin : g_extra_leds
      assign w_unused_hi = ^i_led_row[WD_LED-1:(WD_LED > 4 ? 4 : WD_LED-1)];
    end else begin : g_no_extra_leds
      assign w_unused_hi = 1'b0;
    end
  endgenerate

  // Signals kept for observability/symmetry but not consumed by the decoder
  assign w_unused = ^{r_led0_sync, w_stable[1], w_update[1], w_level[2],
                      w_level[3], w_unused_hi};

  assign w_lit1    = (w_level[1] == MD_LIGHT);
  assign w_clear   = (r_state == ST_IDLE) && w_lit1;
  assign w_qualify = w_stable[2] && w_stable[3] &&
                     is_blink_class(w_class[2]) && is_blink_class(w_class[3]);

  // led[2]/led[3] class pair to status code
  always_comb begin
    w_code = WD_INFO'(CODE_UNKNOWN);
    if ((w_class[2] == CLS_SLOW) && (w_class[3] == CLS_SLOW)) begin
      w_code = WD_INFO'(CODE_NORMAL);
    end else if ((w_class[2] == CLS_SLOW) && (w_class[3] == CLS_FAST)) begin
      w_code = WD_INFO'(CODE_WARN);
    end else if ((w_class[2] == CLS_FAST) && (w_class[3] == CLS_FAST)) begin
      w_code = WD_INFO'(CODE_ERROR);
    end
  end

  // Decoder FSM, result latch, sticky overrun and hold-off timer
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_overrun  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hold_cnt <= '0;
          if (w_lit1) begin
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_qualify) begin
            r_state <= ST_REPORT;
            r_data  <= w_code;
          end else if (w_class[1] == CLS_STEADY_OFF) begin
            r_state <= ST_IDLE;
          end
        end
        ST_REPORT: begin
          // A fresh qualifying classification has nowhere to go
          if (w_qualify && (w_update[2] || w_update[3])) begin
            r_overrun <= 1'b1;
          end
          if (i_info_ready) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (w_lit1) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == C_HOLD_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_info_data  = r_data;
  assign o_info_valid = (r_state == ST_REPORT);
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state == ST_MEASURE);

endmodule

`default_nettype wire

// File: tb/tb_led_blink_decoder.sv
// ============================================================================
// Module      : tb_led_blink_decoder
// Description : Scoreboard bench for led_blink_decoder with NB_FAST=4,
//               NB_SLOW=6, active-low LEDs. Directed blink patterns push the
//               expected code; a monitor pops on every valid/ready handshake.
//               Optional feature macro: LED_DEC_GLITCH_FILTER_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_blink_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] led_row;
  logic [3:0] info_data;
  logic       info_valid;
  logic       info_ready;
  logic       overrun;
  logic       busy;

  int         total;
  int         bad;
  logic [3:0] exp_q[$];

  led_blink_decoder #(
    .WD_LED   (4),
    .WD_INFO  (4),
    .MD_LIGHT (1'b0),
    .NB_FAST  (4),
    .NB_SLOW  (6)
  ) dut (
    .i_sys_clk    (clk),
    .i_rst_n      (rst_n),
    .i_led_row    (led_row),
    .o_info_data  (info_data),
    .o_info_valid (info_valid),
    .i_info_ready (info_ready),
    .o_overrun    (overrun),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a handshake happens on the next rising edge, check it now
  always @(negedge clk) begin
    logic [3:0] exp_code;
    #1;
    if (rst_n && info_valid && info_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL report_unexpected: got code %0h, expected no report", info_data);
      end else begin
        exp_code = exp_q.pop_front();
        if (info_data !== exp_code) begin
          bad++;
          $display("FAIL report_code: got %0h, expected %0h", info_data, exp_code);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Toggle led2/led3 with given periods (0 = hold); optional 1-cycle spikes
  // on led3 in the middle of each 64-cycle slot
  task automatic run_pattern(input int p2, input int p3, input int ncyc, input bit spikes);
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      if (p2 > 0 && (t % p2) == 0) led_row[2] = ~led_row[2];
      if (p3 > 0 && (t % p3) == 0) led_row[3] = ~led_row[3];
      if (spikes && (t % 64) == 32) led_row[3] = ~led_row[3];
      if (spikes && (t % 64) == 33) led_row[3] = ~led_row[3];
    end
  endtask

  // Arm with led1, run a pattern, release led1 and let the decoder idle
  task automatic do_report(input int p2, input int p3, input int ncyc, input logic [3:0] code);
    exp_q.push_back(code);
    led_row[1] = 1'b0;
    tick(4);
    run_pattern(p2, p3, ncyc, 1'b0);
    tick(10);
    led_row[1] = 1'b1;
    tick(300);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    led_row    = 4'hF;
    info_ready = 1'b1;
    tick(5);
    check("reset_valid",   32'(info_valid), 32'd0);
    check("reset_data",    32'(info_data),  32'd0);
    check("reset_overrun", 32'(overrun),    32'd0);
    check("reset_busy",    32'(busy),       32'd0);
    rst_n = 1'b1;
    tick(300);
    check("idle_busy", 32'(busy), 32'd0);

    // SLOW/SLOW -> 0, with busy observed during measurement
    exp_q.push_back(4'h0);
    led_row[1] = 1'b0;
    tick(4);
    check("measure_busy", 32'(busy), 32'd1);
    run_pattern(64, 64, 192, 1'b0);
    tick(10);
    led_row[1] = 1'b1;
    tick(300);
    check("after_hold_busy", 32'(busy), 32'd0);

    do_report(64, 16, 192, 4'h1);   // SLOW/FAST
    do_report(16, 16, 48,  4'h2);   // FAST/FAST
    do_report(16, 64, 192, 4'hF);   // FAST/SLOW

    // Overrun: result pending while another qualifying pair arrives
    info_ready = 1'b0;
    led_row[1] = 1'b0;
    tick(4);
    run_pattern(64, 64, 192, 1'b0);
    tick(10);
    check("pending_valid",   32'(info_valid), 32'd1);
    check("pending_data",    32'(info_data),  32'd0);
    check("pending_overrun", 32'(overrun),    32'd0);
    run_pattern(64, 64, 64, 1'b0);
    tick(10);
    check("overrun_valid", 32'(info_valid), 32'd1);
    check("overrun_data",  32'(info_data),  32'd0);
    check("overrun_flag",  32'(overrun),    32'd1);
    exp_q.push_back(4'h0);
    info_ready = 1'b1;
    tick(3);
    check("overrun_drained_valid", 32'(info_valid), 32'd0);
    led_row[1] = 1'b1;
    tick(300);
    do_report(16, 16, 48, 4'h2);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // No report from a lone led2 blink; led1 held unlit aborts measurement
    led_row[1] = 1'b0;
    tick(4);
    run_pattern(30, 0, 180, 1'b0);
    check("lone_blink_busy",  32'(busy),       32'd1);
    check("lone_blink_valid", 32'(info_valid), 32'd0);
    led_row[1] = 1'b1;
    tick(200);
    check("abort_pending_busy", 32'(busy), 32'd1);
    tick(80);
    check("abort_busy", 32'(busy), 32'd0);
    tick(300);

    // Reset mid-measurement discards everything
    led_row[1] = 1'b0;
    tick(4);
    run_pattern(64, 64, 128, 1'b0);
    check("pre_reset_busy", 32'(busy), 32'd1);
    led_row = 4'hF;
    rst_n = 1'b0;
    tick(3);
    check("midreset_valid",   32'(info_valid), 32'd0);
    check("midreset_data",    32'(info_data),  32'd0);
    check("midreset_overrun", 32'(overrun),    32'd0);
    check("midreset_busy",    32'(busy),       32'd0);
    rst_n = 1'b1;
    tick(300);
    do_report(64, 64, 192, 4'h0);

`ifdef LED_DEC_GLITCH_FILTER_EN
    // Slow pattern with single-cycle spikes on led3 still decodes as 0
    exp_q.push_back(4'h0);
    led_row[1] = 1'b0;
    tick(4);
    run_pattern(64, 64, 192, 1'b1);
    tick(10);
    led_row[1] = 1'b1;
    tick(300);
`endif

    tick(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
